// File: rtl/fetch_unit.sv
// Instruction fetch front end: owns the PC, issues one outstanding imem request at a time,
// and presents one instruction per cycle (with PC, PC+4 and delay-slot flag) to IF/ID.
module fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC0_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Stall,
  input  logic        ExceptionFlush,
  input  logic [31:0] ExceptionVector,
  input  logic        IdIsBranch,
  input  logic        Redirect,
  input  logic [31:0] RedirectTarget,
  output logic        ImemReq,
  output logic [31:0] ImemAddr,
  input  logic        ImemGnt,
  input  logic        ImemRvalid,
  input  logic [31:0] ImemRdata,
  output logic        Valid,
  output logic [31:0] Instruction,
  output logic [31:0] PCOut,
  output logic [31:0] PCAdd4,
  output logic        IsBDS
);

  typedef enum logic [1:0] {S_FETCH, S_WAIT, S_HOLD, S_DRAIN} state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_hold_buf;
  logic        r_bds_pending;
  logic        r_redir_pending;
  logic [31:0] r_redir_tgt;

  state_t      w_state_next;
  logic [31:0] w_pc_add4;
  logic [31:0] w_next_pc;
  logic        w_valid;
  logic        w_consume;
  logic        w_is_bds;
  logic        w_take;
  logic        w_outstanding;

  // Presentation and next-PC selection. A delay slot whose branch already left ID
  // (bubble in IF at the time) steers via the captured target instead of the live one.
  always_comb begin
    w_pc_add4 = r_pc + 32'd4;
    w_valid   = ((r_state == S_WAIT) && ImemRvalid || (r_state == S_HOLD)) && !ExceptionFlush;
    w_consume = w_valid && !Stall;
    w_is_bds  = w_valid && (IdIsBranch || r_bds_pending);
    w_take    = w_is_bds && ((IdIsBranch && Redirect) || r_redir_pending);
    if (w_take)
      w_next_pc = (IdIsBranch && Redirect) ? RedirectTarget : r_redir_tgt;
    else
      w_next_pc = w_pc_add4;
  end

  // NOTE: every signal driven here gets a default first so no path can infer a latch.
  always_comb begin
    w_state_next = r_state;
    ImemReq      = 1'b0;
    ImemAddr     = r_pc;
    unique case (r_state)
      S_FETCH: begin
        ImemReq = 1'b1;
        if (ImemGnt) w_state_next = S_WAIT;
      end
      S_WAIT: begin
        if (w_consume) begin
          // Bypass: request the follower in the same cycle the response is consumed.
          ImemReq      = 1'b1;
          ImemAddr     = w_next_pc;
          w_state_next = ImemGnt ? S_WAIT : S_FETCH;
        end else if (ImemRvalid) begin
          w_state_next = S_HOLD;
        end
      end
      S_HOLD: begin
        if (w_consume) w_state_next = S_FETCH;
      end
      S_DRAIN: begin
        if (ImemRvalid) w_state_next = S_FETCH;
      end
      default: w_state_next = S_FETCH;
    endcase
    w_outstanding = (((r_state == S_WAIT) || (r_state == S_DRAIN)) && !ImemRvalid)
                    || (ImemReq && ImemGnt);
    if (ExceptionFlush) w_state_next = w_outstanding ? S_DRAIN : S_FETCH;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state         <= S_FETCH;
      r_pc            <= RESET_VECTOR;
      r_hold_buf      <= 32'd0;
      r_bds_pending   <= 1'b0;
      r_redir_pending <= 1'b0;
      r_redir_tgt     <= 32'd0;
    end else begin
      r_state <= w_state_next;
      if (ExceptionFlush) begin
        r_pc            <= ExceptionVector;
        r_bds_pending   <= 1'b0;
        r_redir_pending <= 1'b0;
      end else begin
        if (w_consume) begin
          r_pc            <= w_next_pc;
          r_bds_pending   <= 1'b0;
          r_redir_pending <= 1'b0;
        end else if (IdIsBranch && !Stall && !w_valid) begin
          r_bds_pending <= 1'b1;
          if (Redirect) begin
            r_redir_pending <= 1'b1;
            r_redir_tgt     <= RedirectTarget;
          end
        end
        if ((r_state == S_WAIT) && ImemRvalid && Stall) r_hold_buf <= ImemRdata;
      end
    end
  end

  assign Valid       = w_valid;
  assign Instruction = !w_valid ? 32'd0 : ((r_state == S_HOLD) ? r_hold_buf : ImemRdata);
  assign PCOut       = r_pc;
  assign PCAdd4      = w_pc_add4;
  assign IsBDS       = w_is_bds;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a small in-order imem responder with programmable
// response delay, and cycle-by-cycle checks sampled on the falling edge.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        Stall, ExceptionFlush, IdIsBranch, Redirect;
  logic [31:0] ExceptionVector, RedirectTarget;
  logic        ImemReq, ImemGnt, ImemRvalid;
  logic [31:0] ImemAddr, ImemRdata;
  logic        Valid, IsBDS;
  logic [31:0] Instruction, PCOut, PCAdd4;

  // Memory responder state.
  logic        gnt_en;
  int          extra_delay;
  logic        m_pending;
  logic [31:0] m_addr;
  int          m_cnt;
  logic        s_granted, s_took;
  logic [31:0] s_gaddr;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  assign ImemGnt = ImemReq && gnt_en;

  fetch_unit #(.RESET_VECTOR(32'hBFC0_0000)) dut (
    .clk(clk), .rst(rst), .Stall(Stall), .ExceptionFlush(ExceptionFlush),
    .ExceptionVector(ExceptionVector), .IdIsBranch(IdIsBranch), .Redirect(Redirect),
    .RedirectTarget(RedirectTarget), .ImemReq(ImemReq), .ImemAddr(ImemAddr),
    .ImemGnt(ImemGnt), .ImemRvalid(ImemRvalid), .ImemRdata(ImemRdata), .Valid(Valid),
    .Instruction(Instruction), .PCOut(PCOut), .PCAdd4(PCAdd4), .IsBDS(IsBDS)
  );

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'hA5A5_5A5A;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Called at the falling edge: snapshot handshakes, move to just after the next rising edge.
  task automatic adv();
    s_granted = ImemReq && ImemGnt;
    s_gaddr   = ImemAddr;
    s_took    = ImemRvalid;
    @(posedge clk);
    #1;
    if (s_took) m_pending = 1'b0;
    else if (m_pending && m_cnt > 0) m_cnt--;
    if (s_granted) begin
      m_pending = 1'b1;
      m_addr    = s_gaddr;
      m_cnt     = extra_delay;
    end
    ImemRvalid = m_pending && (m_cnt == 0);
    ImemRdata  = ImemRvalid ? instr_of(m_addr) : 32'd0;
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; Stall = 0; ExceptionFlush = 0; IdIsBranch = 0; Redirect = 0;
    ExceptionVector = 0; RedirectTarget = 0; gnt_en = 0; extra_delay = 0;
    m_pending = 0; m_addr = 0; m_cnt = 0; ImemRvalid = 0; ImemRdata = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_valid", {31'd0, Valid}, 32'd0);
    check("rst_instr", Instruction, 32'd0);
    check("rst_isbds", {31'd0, IsBDS}, 32'd0);
    check("rst_pcout", PCOut, 32'hBFC0_0000);
    check("rst_pcadd4", PCAdd4, 32'hBFC0_0004);
    @(posedge clk); #1;
    rst = 1'b0; gnt_en = 1'b1;
    @(negedge clk);

    // C0: first fetch after release.
    check("c0_req", {31'd0, ImemReq}, 32'd1);
    check("c0_addr", ImemAddr, 32'hBFC0_0000);
    check("c0_valid", {31'd0, Valid}, 32'd0);
    adv();
    // C1: first instruction, bypass request for +4.
    check("c1_valid", {31'd0, Valid}, 32'd1);
    check("c1_pcout", PCOut, 32'hBFC0_0000);
    check("c1_instr", Instruction, instr_of(32'hBFC0_0000));
    check("c1_addr", ImemAddr, 32'hBFC0_0004);
    adv();
    // C2..C4: stall while presenting 0xBFC00004.
    Stall = 1'b1; #1;
    check("c2_pcout", PCOut, 32'hBFC0_0004);
    check("c2_req", {31'd0, ImemReq}, 32'd0);
    adv();
    check("c3_valid", {31'd0, Valid}, 32'd1);
    check("c3_instr", Instruction, instr_of(32'hBFC0_0004));
    check("c3_req", {31'd0, ImemReq}, 32'd0);
    adv();
    check("c4_pcout", PCOut, 32'hBFC0_0004);
    check("c4_instr", Instruction, instr_of(32'hBFC0_0004));
    adv();
    // C5: stall released, held instruction consumed from HOLD.
    Stall = 1'b0; #1;
    check("c5_valid", {31'd0, Valid}, 32'd1);
    check("c5_instr", Instruction, instr_of(32'hBFC0_0004));
    adv();
    check("c6_addr", ImemAddr, 32'hBFC0_0008);
    check("c6_valid", {31'd0, Valid}, 32'd0);
    adv();
    // C7: branch at 0xBFC00004 in ID, delay slot 0xBFC00008 valid in IF.
    IdIsBranch = 1; Redirect = 1; RedirectTarget = 32'h8000_0100; #1;
    check("c7_pcout", PCOut, 32'hBFC0_0008);
    check("c7_isbds", {31'd0, IsBDS}, 32'd1);
    check("c7_addr", ImemAddr, 32'h8000_0100);
    adv();
    IdIsBranch = 0; Redirect = 0; #1;
    check("c8_pcout", PCOut, 32'h8000_0100);
    check("c8_isbds", {31'd0, IsBDS}, 32'd0);
    check("c8_instr", Instruction, instr_of(32'h8000_0100));
    check("c8_pcadd4", PCAdd4, 32'h8000_0104);
    adv();
    // C9..C12: branch leaves ID ahead of a delayed delay slot.
    extra_delay = 2;
    check("c9_pcout", PCOut, 32'h8000_0104);
    check("c9_addr", ImemAddr, 32'h8000_0108);
    adv();
    IdIsBranch = 1; Redirect = 1; RedirectTarget = 32'h8000_0200; #1;
    check("c10_valid", {31'd0, Valid}, 32'd0);
    check("c10_isbds", {31'd0, IsBDS}, 32'd0);
    adv();
    IdIsBranch = 0; Redirect = 0; RedirectTarget = 32'hDEAD_BEEF; #1;
    check("c11_valid", {31'd0, Valid}, 32'd0);
    adv();
    extra_delay = 0;
    check("c12_pcout", PCOut, 32'h8000_0108);
    check("c12_isbds", {31'd0, IsBDS}, 32'd1);
    check("c12_addr", ImemAddr, 32'h8000_0200);
    adv();
    // C13..C18: exception flush while a response is outstanding.
    extra_delay = 2;
    check("c13_pcout", PCOut, 32'h8000_0200);
    check("c13_isbds", {31'd0, IsBDS}, 32'd0);
    adv();
    IdIsBranch = 1; Redirect = 1; RedirectTarget = 32'h8000_0300; #1;
    check("c14_valid", {31'd0, Valid}, 32'd0);
    adv();
    IdIsBranch = 0; Redirect = 0; ExceptionFlush = 1; ExceptionVector = 32'h8000_0180; #1;
    check("c15_valid", {31'd0, Valid}, 32'd0);
    check("c15_req", {31'd0, ImemReq}, 32'd0);
    adv();
    ExceptionFlush = 0; extra_delay = 0; #1;
    check("c16_stale_valid", {31'd0, Valid}, 32'd0);
    check("c16_stale_instr", Instruction, 32'd0);
    check("c16_req", {31'd0, ImemReq}, 32'd0);
    check("c16_pcout", PCOut, 32'h8000_0180);
    adv();
    check("c17_req", {31'd0, ImemReq}, 32'd1);
    check("c17_addr", ImemAddr, 32'h8000_0180);
    adv();
    check("c18_pcout", PCOut, 32'h8000_0180);
    check("c18_isbds", {31'd0, IsBDS}, 32'd0);
    check("c18_addr", ImemAddr, 32'h8000_0184);
    adv();
    // C19: flush together with stall and a taken branch; vector at top of address space.
    Stall = 1; IdIsBranch = 1; Redirect = 1; RedirectTarget = 32'h8000_0400;
    ExceptionFlush = 1; ExceptionVector = 32'hFFFF_FFFC; #1;
    check("c19_valid", {31'd0, Valid}, 32'd0);
    check("c19_isbds", {31'd0, IsBDS}, 32'd0);
    check("c19_req", {31'd0, ImemReq}, 32'd0);
    adv();
    Stall = 0; IdIsBranch = 0; Redirect = 0; ExceptionFlush = 0; #1;
    check("c20_pcout", PCOut, 32'hFFFF_FFFC);
    check("c20_pcadd4", PCAdd4, 32'd0);
    check("c20_addr", ImemAddr, 32'hFFFF_FFFC);
    adv();
    check("c21_valid", {31'd0, Valid}, 32'd1);
    check("c21_instr", Instruction, instr_of(32'hFFFF_FFFC));
    check("c21_addr", ImemAddr, 32'd0);
    adv();
    check("c22_pcout", PCOut, 32'd0);
    check("c22_pcadd4", PCAdd4, 32'd4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
